// File: rtl/addsub_sat_pipe.sv
// addsub_sat_pipe: pipelined saturating two's-complement add/subtract unit.
// The carry chain is cut into STAGES slices of WIDTH/STAGES bits each.
// Stage k adds slice k using the carry registered by stage k-1.
// The whole pipe advances on ~out_valid | out_ready and holds otherwise.
// The last stage computes overflow and saturation and loads the output register.
module addsub_sat_pipe #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 2,
   parameter int SAT_EN = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             ovfl,
   output logic             neg,
   output logic             zero,
   output logic             sticky_ovfl,
   input  logic             clr_sticky
);

   localparam int SW = WIDTH / STAGES;

   // One pipeline slot: the operands travel with the partial sum and the carry.
   // The operand MSBs are still needed at the end to detect overflow.
   typedef struct packed {
      logic             v;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [WIDTH-1:0] s;
      logic             c;
   } stage_t;

   logic advance;

   // Every stage moves together when the output slot is empty or being drained.
   assign advance  = ~out_valid | out_ready;
   assign in_ready = advance;

   genvar k;
   generate
      for (k = 0; k < STAGES; k++) begin : g_st
         stage_t      q;      // state entering stage k
         stage_t      d;      // state leaving stage k
         logic [SW:0] slice;  // slice k sum with its carry-out

         if (k == 0) begin : g_src
            // Subtraction is A + ~B + 1, so the carry-in is the sub bit.
            // Field order is v, a, b, s, c.
            assign q = {in_valid, a, (sub ? ~b : b), {WIDTH{1'b0}}, sub};
         end else begin : g_reg
            // Pipeline register between stage k-1 and stage k; it holds while stalled.
            // NOTE: the data fields are reset together with v so no X can reach the outputs;
            // these are ordinary flops, not a memory array.
            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) begin
                  q <= '0;
               end else if (advance) begin
                  // NOTE: non-blocking assignment, so each stage samples its neighbour's
                  // value from before the clock edge.
                  q <= g_st[k-1].d;
               end
            end
         end

         // Resolve slice k of the carry chain and pass everything else through.
         always_comb begin
            // NOTE: d starts as a full copy of q, so every field is assigned on every
            // path and no latch can be inferred.
            d     = q;
            slice = {1'b0, q.a[k*SW +: SW]} + {1'b0, q.b[k*SW +: SW]} + {{SW{1'b0}}, q.c};
            d.s[k*SW +: SW] = slice[SW-1:0];
            d.c   = slice[SW];
         end
      end
   endgenerate

   stage_t           last;
   logic             raw_ovfl;
   logic [WIDTH-1:0] sat_res;
   logic             unused_bits;

   assign last = g_st[STAGES-1].d;

   // The final carry-out and the operand bits below the MSB are not needed for the result.
   assign unused_bits = ^{last.c, last.a[WIDTH-2:0], last.b[WIDTH-2:0]};

   // Signed overflow, then saturation toward the sign of A.
   always_comb begin
      raw_ovfl = (last.a[WIDTH-1] == last.b[WIDTH-1]) & (last.s[WIDTH-1] != last.a[WIDTH-1]);
      sat_res  = last.s;
      if ((SAT_EN != 0) && raw_ovfl) begin
         sat_res = last.a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end
   end

   // Output register: it loads the finished result and its flags on every advance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         result    <= '0;
         ovfl      <= 1'b0;
         neg       <= 1'b0;
         zero      <= 1'b0;
      end else if (advance) begin
         out_valid <= last.v;
         result    <= sat_res;
         ovfl      <= raw_ovfl;
         neg       <= sat_res[WIDTH-1];
         zero      <= (sat_res == '0);
      end
   end

   // Sticky overflow: set by a delivered overflow result; a set in the same cycle beats a clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sticky_ovfl <= 1'b0;
      end else if (out_valid && out_ready && ovfl) begin
         sticky_ovfl <= 1'b1;
      end else if (clr_sticky) begin
         sticky_ovfl <= 1'b0;
      end
   end

endmodule

// File: tb/tb_addsub_sat_pipe.sv
// Directed bench for addsub_sat_pipe.
// It drives a saturating instance and a wrapping instance, both with WIDTH=16 and STAGES=2.
// Inputs change on the falling edge of clk and outputs are sampled there as well.
module tb_addsub_sat_pipe;

   logic        clk;
   logic        rst_n;

   // saturating instance
   logic        in_valid, in_ready, sub, out_valid, out_ready;
   logic [15:0] a, b, result;
   logic        ovfl, neg, zero, sticky_ovfl, clr_sticky;

   // wrapping instance
   logic        w_in_valid, w_in_ready, w_sub, w_out_valid, w_out_ready;
   logic [15:0] w_a, w_b, w_result;
   logic        w_ovfl, w_neg, w_zero, w_sticky_ovfl, w_clr_sticky;

   int          n_checks = 0;
   int          n_errors = 0;

   addsub_sat_pipe #(.WIDTH(16), .STAGES(2), .SAT_EN(1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .ovfl(ovfl), .neg(neg), .zero(zero),
      .sticky_ovfl(sticky_ovfl), .clr_sticky(clr_sticky)
   );

   addsub_sat_pipe #(.WIDTH(16), .STAGES(2), .SAT_EN(0)) dut_wrap (
      .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
      .a(w_a), .b(w_b), .sub(w_sub), .out_valid(w_out_valid), .out_ready(w_out_ready),
      .result(w_result), .ovfl(w_ovfl), .neg(w_neg), .zero(w_zero),
      .sticky_ovfl(w_sticky_ovfl), .clr_sticky(w_clr_sticky)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Send one op, then check the output two cycles later with out_ready held high.
   task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                         input logic ts, input logic [15:0] e_res, input logic e_ov,
                         input logic e_neg, input logic e_zero);
      @(negedge clk);
      a = ta; b = tb; sub = ts; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      check({tag, ".valid"}, out_valid, 1'b1);
      check({tag, ".result"}, result, e_res);
      check({tag, ".ovfl"}, ovfl, e_ov);
      check({tag, ".neg"}, neg, e_neg);
      check({tag, ".zero"}, zero, e_zero);
   endtask

   // Stream vectors, with results worked out by hand (SAT_EN=1).
   logic [15:0] s_a   [6] = '{16'h0001, 16'h0100, 16'h7000, 16'hFFFF, 16'h8000, 16'h0050};
   logic [15:0] s_b   [6] = '{16'h0002, 16'h0001, 16'h1000, 16'h0001, 16'hFFFF, 16'h0060};
   logic        s_sub [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
   logic [15:0] s_exp [6] = '{16'h0003, 16'h00FF, 16'h7FFF, 16'h0000, 16'h8000, 16'hFFF0};

   initial begin
      int idx;
      int ptr;

      rst_n = 1'b0;
      in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b1; clr_sticky = 1'b0;
      w_in_valid = 1'b0; w_a = '0; w_b = '0; w_sub = 1'b0; w_out_ready = 1'b1; w_clr_sticky = 1'b0;

      // ---- reset state ----
      #12;
      check("rst.out_valid", out_valid, 1'b0);
      check("rst.result", result, 16'h0000);
      check("rst.ovfl", ovfl, 1'b0);
      check("rst.neg", neg, 1'b0);
      check("rst.zero", zero, 1'b0);
      check("rst.sticky", sticky_ovfl, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst.in_ready", in_ready, 1'b1);

      // ---- directed arithmetic ----
      run_op("max_plus_1", 16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      check("max_plus_1.sticky", sticky_ovfl, 1'b1);
      run_op("min_minus_1", 16'h8000, 16'h0001, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0);
      run_op("zero_minus_min", 16'h0000, 16'h8000, 1'b1, 16'h7FFF, 1'b1, 1'b0, 1'b0);
      run_op("equal_sub", 16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);
      run_op("slice_carry", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
      run_op("min_minus_min", 16'h8000, 16'h8000, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);
      run_op("small_neg", 16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b1, 1'b0);

      // ---- stream with out_ready low in cycles 3-5 ----
      idx = 0;
      ptr = 0;
      for (int c = 0; c < 14; c++) begin
         @(negedge clk);
         out_ready = !(c >= 3 && c <= 5);
         if (idx < 6) begin
            a = s_a[idx]; b = s_b[idx]; sub = s_sub[idx]; in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         #1;
         check($sformatf("stream.in_ready.c%0d", c), in_ready, (c >= 3 && c <= 5) ? 1'b0 : 1'b1);
         if (c >= 3 && c <= 5) check($sformatf("stream.held_valid.c%0d", c), out_valid, 1'b1);
         if (out_valid) begin
            if (ptr < 6) check($sformatf("stream.result%0d.c%0d", ptr, c), result, s_exp[ptr]);
            else check($sformatf("stream.extra.c%0d", c), 1'b1, 1'b0);
            if (out_ready) ptr++;
         end
         if (in_valid && in_ready) idx++;
      end
      in_valid = 1'b0;
      check("stream.delivered", ptr, 6);
      check("stream.accepted", idx, 6);

      // ---- wrapping instance and sticky set/clear priority ----
      @(negedge clk);
      w_a = 16'h7FFF; w_b = 16'h0001; w_sub = 1'b0; w_in_valid = 1'b1;
      @(negedge clk);
      w_in_valid = 1'b0;
      @(negedge clk);
      check("wrap.valid", w_out_valid, 1'b1);
      check("wrap.result", w_result, 16'h8000);
      check("wrap.ovfl", w_ovfl, 1'b1);
      check("wrap.neg", w_neg, 1'b1);
      check("wrap.sticky_before", w_sticky_ovfl, 1'b0);
      w_clr_sticky = 1'b1;  // same cycle as the overflow transfer
      @(negedge clk);
      check("wrap.sticky_set_wins", w_sticky_ovfl, 1'b1);
      @(negedge clk);
      check("wrap.sticky_cleared", w_sticky_ovfl, 1'b0);
      w_clr_sticky = 1'b0;

      // ---- asynchronous reset during a stall with two ops in flight ----
      @(negedge clk);
      out_ready = 1'b0;
      a = 16'h0011; b = 16'h0022; sub = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      a = 16'h0033; b = 16'h0044; sub = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      check("stall.valid", out_valid, 1'b1);
      check("stall.result", result, 16'h0033);
      check("stall.in_ready", in_ready, 1'b0);
      #1;
      rst_n = 1'b0;
      #1;
      check("async_rst.out_valid", out_valid, 1'b0);
      check("async_rst.result", result, 16'h0000);
      check("async_rst.sticky", sticky_ovfl, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      #1;
      check("post_rst.in_ready", in_ready, 1'b1);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check($sformatf("post_rst.no_ghost.c%0d", c), out_valid, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/addsub_sat_pipe.md
Name: addsub_sat_pipe

Overview:
Parametrised, pipelined, saturating two's-complement add/subtract unit with a valid/ready handshake. It is the next-generation ALU adder for the datapath. Width, pipeline depth and saturation mode are configurable. The carry chain is split across STAGES register stages so that wide operands meet timing. Per-result flags (N, Z, V) and a sticky overflow flag feed the flag register.

Parameters:
WIDTH, 16, operand/result width in bits; must be >= 4 and divisible by STAGES.
STAGES, 2, number of pipeline stages; legal values 1..4; each stage resolves WIDTH/STAGES bits of the carry chain.
SAT_EN, 1, 1 = saturate on overflow; 0 = wrap (raw sum) and flag only.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  operands and op are valid this cycle.
in_ready  out  1  pipeline accepts input this cycle.
a  in  WIDTH  operand A, signed.
b  in  WIDTH  operand B, signed.
sub  in  1  0 = A+B, 1 = A-B.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts result.
result  out  WIDTH  sum or difference, saturated when SAT_EN=1.
ovfl  out  1  signed overflow occurred for this result.
neg  out  1  result[WIDTH-1].
zero  out  1  result == 0.
sticky_ovfl  out  1  set by any delivered overflow; cleared by clr_sticky.
clr_sticky  in  1  synchronous clear of sticky_ovfl.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset (rst_n=0): all stage valid bits = 0; out_valid=0, result=0, ovfl=0, neg=0, zero=0 (output register reset, not derived); sticky_ovfl=0. Any data in flight is discarded. in_ready=1 once reset is released.
- Handshake:
  - Transfer in when in_valid & in_ready.
  - Transfer out when out_valid & out_ready.
  - in_ready = ~out_valid | out_ready. The pipeline advances as a whole on that condition and holds every stage otherwise.
  - While stalled, result and flags stay stable.
  - Bubbles (in_valid=0 on an advance) propagate as invalid stages.
- Latency: exactly STAGES cycles from input accept to out_valid when out_ready is held high. Throughput is 1 op/cycle.
- Arithmetic:
  - b_eff = sub ? ~b : b; carry-in = sub.
  - Stage k adds slice k with the carry registered from stage k-1.
  - Not-yet-consumed upper slices of a, b_eff and the completed lower sum slices are carried forward in pipeline registers.
- Overflow: ovfl = (a_msb == b_eff_msb) & (raw_msb != a_msb), using the a and b_eff values that entered with that op.
- Saturation (SAT_EN=1): on ovfl, result = a_msb ? min (1 followed by zeros) : max (0 followed by ones). Saturation is directed by the sign of A for both add and sub. With no ovfl, result = raw.
- SAT_EN=0: result = raw (wrapped); ovfl still reported.
- neg and zero are computed from the final (post-saturation) result.
- sticky_ovfl:
  - Set on an output transfer with ovfl=1.
  - clr_sticky clears it.
  - Simultaneous set and clear: set wins, so sticky_ovfl=1.
  - Not affected by stalls.
- Boundaries:
  - Full pipe with out_ready=0: in_ready=0, no input is lost or duplicated.
  - out_ready rising with in_valid: accept and advance in the same cycle.
  - min - min: 0, no ovfl.
  - 0 - min: overflow, saturates to max.
  - rst_n asserted mid-stall: outputs return to reset values immediately (asynchronously).

Test Plan:
- WIDTH=16, STAGES=2, SAT_EN=1, out_ready=1: a=0x7FFF, b=0x0001, sub=0 -> after 2 cycles result=0x7FFF, ovfl=1, neg=0, sticky_ovfl=1 the following cycle.
- a=0x8000, b=0x0001, sub=1 -> result=0x8000, ovfl=1, neg=1. Then a=0x0000, b=0x8000, sub=1 -> result=0x7FFF, ovfl=1.
- a=0x1234, b=0x1234, sub=1 -> result=0x0000, zero=1, ovfl=0. Also a=0x00FF, b=0x0001, sub=0 -> 0x0100, exercising the carry across the stage boundary.
- Stream 6 ops with out_ready low for cycles 3-5 -> in_ready=0 while the pipe is full, outputs held stable, all 6 results delivered in order with no loss or duplication.
- SAT_EN=0 instance: 0x7FFF + 0x0001 -> result=0x8000, ovfl=1. Assert clr_sticky on the same cycle as that output transfer -> sticky_ovfl=1. clr_sticky on the next cycle -> sticky_ovfl=0.
- Drive rst_n low while 2 valid ops are in flight and out_ready=0 -> out_valid=0 and result=0 immediately. After release, in_ready=1 and the flushed ops never appear.
